// File: rtl/matmul_arbiter.sv
// matmul_arbiter: two-requester front end for one shared, fixed-latency 2x2
// matrix multiplier. It accepts one job at a time, pulses mm_start, waits
// LATENCY cycles, captures mm_result and returns it to the requester that
// owns the job.
// Optional feature macro: MATMUL_ARB_ROUND_ROBIN_EN. When it is defined,
// conflicts are arbitrated round robin. When it is undefined, requester 0
// has fixed priority.
module matmul_arbiter #(
    parameter int LATENCY = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [11:0] req0_A,
    input  logic [11:0] req0_B,
    input  logic [11:0] req1_A,
    input  logic [11:0] req1_B,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [23:0] resp_result,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic        mm_start,
    output logic [11:0] mm_A,
    output logic [11:0] mm_B,
    input  logic [23:0] mm_result,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_RESPOND
    } state_t;

    // WAIT spans LATENCY cycles: the counter is loaded in START and WAIT exits at zero.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [11:0] r_op_a;
    logic [11:0] r_op_b;
    logic        r_id;
    logic [23:0] r_result;
    logic        w_gnt1;
    logic        w_accept;
    logic        w_resp_done;
    logic        w_hold_ops;

`ifdef MATMUL_ARB_ROUND_ROBIN_EN
    logic r_last;

    // Remember who was served last; reset favours requester 0 on the first conflict.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_accept)
            r_last <= w_gnt1;
    end

    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);
`else
    assign w_gnt1 = req1_valid & ~req0_valid;
`endif

    // Grant is purely combinational, so a lone requester is accepted with no bubble.
    assign req0_ready  = (r_state == S_IDLE) & req0_valid & ~w_gnt1;
    assign req1_ready  = (r_state == S_IDLE) & w_gnt1;
    assign w_accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_resp_done = r_id ? resp1_ready : resp0_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; the non-owner's response ready is never looked at
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_START;
            S_START:   w_next = S_WAIT;
            S_WAIT:    if (r_cnt == 4'd0) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESPOND;
            S_RESPOND: if (w_resp_done) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Job datapath: operand/owner latch, latency counter, result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_id     <= 1'b0;
            r_cnt    <= 4'd0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op_a <= w_gnt1 ? req1_A : req0_A;
                r_op_b <= w_gnt1 ? req1_B : req0_B;
                r_id   <= w_gnt1;
            end
            if (r_state == S_START)
                r_cnt <= CNT_LOAD;
            else if (r_state == S_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == S_CAPTURE)
                r_result <= mm_result;
        end
    end

    // Operands are presented only while the multiplier owns the job.
    assign w_hold_ops  = (r_state == S_START) | (r_state == S_WAIT) | (r_state == S_CAPTURE);
    assign mm_start    = (r_state == S_START);
    assign mm_A        = w_hold_ops ? r_op_a : 12'd0;
    assign mm_B        = w_hold_ops ? r_op_b : 12'd0;
    assign resp0_valid = (r_state == S_RESPOND) & ~r_id;
    assign resp1_valid = (r_state == S_RESPOND) & r_id;
    assign resp_result = r_result;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_matmul_arbiter.sv
// Bench for matmul_arbiter: the bench supplies a behavioural multiplier that
// is valid only around the expected capture window and is random at all other
// times. The bench also keeps a grant / matrix-product reference model.
module tb_matmul_arbiter;

    localparam int LAT = 11;
`ifdef MATMUL_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [11:0] req0_A, req0_B, req1_A, req1_B;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [23:0] resp_result;
    logic        resp0_ready, resp1_ready;
    logic        mm_start;
    logic [11:0] mm_A, mm_B;
    logic [23:0] mm_result;
    logic        busy;

    int errs;
    int checks;
    int last_srv;
    int who;
    int exp_seq[4];
    logic [23:0] garb;
    int mm_age;

    matmul_arbiter #(.LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_result(resp_result),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .mm_start(mm_start), .mm_A(mm_A), .mm_B(mm_B), .mm_result(mm_result),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference 2x2 signed matrix product C = A*B, element i at bits [3i+2:3i].
    function automatic logic [23:0] mm_ref(input logic [11:0] a, input logic [11:0] b);
        int ea[4];
        int eb[4];
        int c[4];
        logic signed [2:0] t;
        logic [23:0] r;
        for (int i = 0; i < 4; i++) begin
            t = a[3*i +: 3]; ea[i] = int'(t);
            t = b[3*i +: 3]; eb[i] = int'(t);
        end
        c[0] = ea[0]*eb[0] + ea[1]*eb[2];
        c[1] = ea[0]*eb[1] + ea[1]*eb[3];
        c[2] = ea[2]*eb[0] + ea[3]*eb[2];
        c[3] = ea[2]*eb[1] + ea[3]*eb[3];
        for (int i = 0; i < 4; i++) r[6*i +: 6] = 6'(c[i]);
        return r;
    endfunction

    // Multiplier model: mm_age counts cycles since mm_start; the output is junk outside the result window.
    always @(posedge clock or posedge reset) begin
        if (reset) mm_age <= 0;
        else if (mm_start) mm_age <= 1;
        else if (mm_age != 0 && mm_age < 100) mm_age <= mm_age + 1;
    end
    always @(posedge clock) garb <= 24'($urandom);
    assign mm_result = (mm_age == LAT || mm_age == LAT + 1) ? mm_ref(mm_A, mm_B) : garb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge in IDLE. Checks the grant against the model, then clocks the accept.
    task automatic accept(input bit v0, input bit v1, input bit keep, output int w);
        int exp;
        req0_valid = v0;
        req1_valid = v1;
        #1;
        if (v0 && v1) exp = RR ? 1 - last_srv : 0;
        else          exp = v0 ? 0 : 1;
        chk("grant0", req0_ready, exp == 0);
        chk("grant1", req1_ready, exp == 1);
        last_srv = exp;
        w = exp;
        @(negedge clock);
        if (!keep) begin req0_valid = 0; req1_valid = 0; end
    endtask

    // Call at the negedge of the START cycle. Follows the job through to the response handshake.
    task automatic finish_job(input int id, input logic [11:0] a, input logic [11:0] b,
                              input logic [23:0] exp_res, input int hold, input bit stray);
        int n;
        int starts;
        bit got;
        bit spur;
        n = 0; starts = 0; got = 0; spur = 0;
        chk("mm_A_start", mm_A, a);
        chk("mm_B_start", mm_B, b);
        chk("busy_start", busy, 1);
        if (stray) begin
            if (id == 0) resp1_ready = 1; else resp0_ready = 1;
        end
        while (!got && n < 40) begin
            starts += int'(mm_start);
            if ((id == 0 ? resp0_valid : resp1_valid) === 1'b1) got = 1;
            else begin
                if ((id == 0 ? resp1_valid : resp0_valid) !== 1'b0) spur = 1;
                @(negedge clock);
                n++;
            end
        end
        chk("resp_latency", n, LAT + 2);
        chk("mm_start_pulses", starts, 1);
        chk("no_wrong_resp", spur, 0);
        chk("resp_result", resp_result, exp_res);
        chk("other_valid", id == 0 ? resp1_valid : resp0_valid, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            chk("hold_valid", id == 0 ? resp0_valid : resp1_valid, 1);
            chk("hold_result", resp_result, exp_res);
            chk("hold_busy", busy, 1);
            chk("hold_no_accept", req0_ready | req1_ready, 0);
        end
        if (id == 0) resp0_ready = 1; else resp1_ready = 1;
        @(negedge clock);
        resp0_ready = 0;
        resp1_ready = 0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", resp0_valid | resp1_valid, 0);
        chk("idle_mm_A", mm_A, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mm_start"}, mm_start, 0);
        chk({tag, "_mm_A"}, mm_A, 0);
        chk({tag, "_mm_B"}, mm_B, 0);
        chk({tag, "_resp_result"}, resp_result, 0);
        chk({tag, "_resp_valid"}, {resp1_valid, resp0_valid}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] a, b;
        int pat;
        errs = 0; checks = 0; last_srv = 1;
        reset = 1; req0_valid = 0; req1_valid = 0;
        req0_A = 0; req0_B = 0; req1_A = 0; req1_B = 0;
        resp0_ready = 0; resp1_ready = 0;
        repeat (2) @(negedge clock);
        chk_reset_outputs("rst");
        reset = 0;
        @(negedge clock);

        // Single job on requester 0
        req0_A = 12'b011_010_001_000; req0_B = 12'b000_001_010_011;
        accept(1, 0, 0, who);
        finish_job(0, 12'b011_010_001_000, 12'b000_001_010_011, 24'b000100_001001_000000_000001, 0, 0);

        // Signed job on requester 1
        req1_A = 12'b111_101_110_100; req1_B = 12'b101_000_101_110;
        accept(0, 1, 0, who);
        finish_job(1, 12'b111_101_110_100, 12'b101_000_101_110, 24'b001100_000110_010010_001000, 1, 0);

        // Stray resp0_ready while requester 1 owns the job
        req1_A = 12'($urandom); req1_B = 12'($urandom);
        accept(0, 1, 0, who);
        finish_job(1, req1_A, req1_B, mm_ref(req1_A, req1_B), 2, 1);

        // Back-pressure: requester 0 waits behind a stalled requester 1 response
        req1_A = 12'($urandom); req1_B = 12'($urandom);
        req0_A = 12'($urandom); req0_B = 12'($urandom);
        accept(0, 1, 0, who);
        req0_valid = 1;
        finish_job(1, req1_A, req1_B, mm_ref(req1_A, req1_B), 5, 0);
        accept(1, 0, 0, who);
        finish_job(0, req0_A, req0_B, mm_ref(req0_A, req0_B), 0, 0);

        // Reset in WAIT while the counter holds 5
        req0_A = 12'($urandom); req0_B = 12'($urandom);
        accept(1, 0, 0, who);
        repeat (6) @(negedge clock);
        reset = 1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clock);
        reset = 0;
        last_srv = 1;
        req1_A = 12'($urandom); req1_B = 12'($urandom);
        accept(0, 1, 0, who);
        finish_job(1, req1_A, req1_B, mm_ref(req1_A, req1_B), 0, 0);

        // Both requesters valid continuously for four jobs
        if (RR) begin exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1; end
        else    begin exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0; end
        req0_A = 12'($urandom); req0_B = 12'($urandom);
        req1_A = 12'($urandom); req1_B = 12'($urandom);
        for (int j = 0; j < 4; j++) begin
            accept(1, 1, 1, who);
            chk("conflict_order", who, exp_seq[j]);
            a = (who == 1) ? req1_A : req0_A;
            b = (who == 1) ? req1_B : req0_B;
            finish_job(who, a, b, mm_ref(a, b), 0, 0);
        end
        req0_valid = 0; req1_valid = 0;

        // Randomized jobs: random requester pattern, operands, stall length, and stray ready
        for (int j = 0; j < 6; j++) begin
            pat = $urandom_range(1, 3);
            req0_A = 12'($urandom); req0_B = 12'($urandom);
            req1_A = 12'($urandom); req1_B = 12'($urandom);
            accept(pat[0], pat[1], 0, who);
            a = (who == 1) ? req1_A : req0_A;
            b = (who == 1) ? req1_B : req0_B;
            finish_job(who, a, b, mm_ref(a, b), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // A dropped requester leaves nothing queued
        repeat (3) @(negedge clock);
        chk("no_queued_job", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
